// File: rtl/wt_dcache_rd_client.sv
// -----------------------------------------------------------------------------
// wt_dcache_rd_client
//
// Load-side initiator for one read port of the write-through dcache memory.
// Takes one load at a time from the LSU, arbitrates for the memory read port,
// presents the physical tag the cycle after the grant and evaluates the hit.
// On a miss, or when the cache is disabled, it raises a miss request and
// forwards the returned word. Only one miss can be outstanding.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   enable_i             cache enable (0: every load is a noncacheable miss)
//   req_* / req_gnt_o    LSU load request, address and grant
//   tag_i                physical tag, valid the cycle after req_gnt_o
//   kill_i               abort the outstanding load
//   rsp_valid_o/data_o   single-cycle load response
//   rd_*                 memory read-port request / grant / hit / data
//   miss_*               miss request, acknowledge and data return
// -----------------------------------------------------------------------------
module wt_dcache_rd_client #(
    parameter int unsigned TagWidth = 44,
    parameter int unsigned IdxWidth = 8,
    parameter int unsigned OffWidth = 4,
    parameter int unsigned SetAssoc = 8,
    parameter logic        HighPrio = 1'b0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  enable_i,
    // LSU side
    input  logic                                  req_i,
    input  logic [IdxWidth-1:0]                   req_idx_i,
    input  logic [OffWidth-1:0]                   req_off_i,
    input  logic [1:0]                            req_size_i,
    output logic                                  req_gnt_o,
    input  logic [TagWidth-1:0]                   tag_i,
    input  logic                                  kill_i,
    output logic                                  rsp_valid_o,
    output logic [63:0]                           rsp_data_o,
    // memory read port
    output logic                                  rd_req_o,
    input  logic                                  rd_ack_i,
    output logic [IdxWidth-1:0]                   rd_idx_o,
    output logic [OffWidth-1:0]                   rd_off_o,
    output logic [TagWidth-1:0]                   rd_tag_o,
    output logic                                  rd_tag_only_o,
    output logic                                  rd_prio_o,
    input  logic [SetAssoc-1:0]                   rd_hit_oh_i,
    input  logic [63:0]                           rd_data_i,
    // miss interface
    output logic                                  miss_req_o,
    input  logic                                  miss_ack_i,
    output logic                                  miss_nc_o,
    output logic [TagWidth+IdxWidth+OffWidth-1:0] miss_paddr_o,
    output logic [1:0]                            miss_size_o,
    input  logic                                  miss_rtrn_i,
    input  logic [63:0]                           miss_data_i
);

    typedef enum logic [2:0] {
        IDLE,
        TAG_CMP,
        MISS_REQ,
        MISS_WAIT,
        KILL_WAIT
    } state_e;

    state_e state_q, state_d;

    // Load context captured at grant (address, size, cacheability) and in
    // the tag-compare cycle (tag); it feeds the miss request fields.
    logic [IdxWidth-1:0] idx_q;
    logic [OffWidth-1:0] off_q;
    logic [1:0]          size_q;
    logic                nc_q;
    logic [TagWidth-1:0] tag_q;

    logic latch_req;
    logic latch_tag;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned below gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        req_gnt_o   = 1'b0;
        rd_req_o    = 1'b0;
        rd_idx_o    = idx_q;
        rd_off_o    = off_q;
        rd_tag_o    = tag_q;
        rsp_valid_o = 1'b0;
        rsp_data_o  = '0;
        miss_req_o  = 1'b0;
        latch_req   = 1'b0;
        latch_tag   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The LSU address goes straight to the read port; the LSU holds
                // it until the arbiter grants.
                rd_req_o = req_i;
                rd_idx_o = req_idx_i;
                rd_off_o = req_off_i;
                if (req_i && rd_ack_i) begin
                    req_gnt_o = 1'b1;
                    latch_req = 1'b1;
                    state_d   = TAG_CMP;
                end
            end

            TAG_CMP: begin
                // The tag arrives only now, so it bypasses the register
                // towards the memory compare.
                rd_tag_o  = tag_i;
                latch_tag = 1'b1;
                if (kill_i) begin
                    state_d = IDLE;
                end else if ((|rd_hit_oh_i) && !nc_q) begin
                    rsp_valid_o = 1'b1;
                    rsp_data_o  = rd_data_i;
                    state_d     = IDLE;
                end else begin
                    state_d = MISS_REQ;
                end
            end

            MISS_REQ: begin
                miss_req_o = 1'b1;
                if (miss_ack_i) begin
                    // Once accepted, the miss returns data regardless of kill,
                    // so a killed load must still drain the return.
                    state_d = kill_i ? KILL_WAIT : MISS_WAIT;
                end else if (kill_i) begin
                    state_d = IDLE;
                end
            end

            MISS_WAIT: begin
                if (kill_i) begin
                    // A return arriving together with the kill is the one
                    // being waited for, so the load is finished either way.
                    state_d = miss_rtrn_i ? IDLE : KILL_WAIT;
                end else if (miss_rtrn_i) begin
                    rsp_valid_o = 1'b1;
                    rsp_data_o  = miss_data_i;
                    state_d     = IDLE;
                end
            end

            KILL_WAIT: begin
                if (miss_rtrn_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset silences every handshake in the same cycle so nothing is
        // granted, requested or answered while the block is being cleared.
        if (rst_i) begin
            state_d     = IDLE;
            req_gnt_o   = 1'b0;
            rd_req_o    = 1'b0;
            rd_idx_o    = '0;
            rd_off_o    = '0;
            rd_tag_o    = '0;
            rsp_valid_o = 1'b0;
            rsp_data_o  = '0;
            miss_req_o  = 1'b0;
            latch_req   = 1'b0;
            latch_tag   = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State and context registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the context registers are cleared as well because they
            // drive miss_* outputs directly, which must read 0 out of reset.
            state_q <= IDLE;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            nc_q    <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            if (latch_req) begin
                idx_q  <= req_idx_i;
                off_q  <= req_off_i;
                size_q <= req_size_i;
                nc_q   <= ~enable_i;
            end
            if (latch_tag) begin
                tag_q <= tag_i;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Static and registered outputs
    // -------------------------------------------------------------------------
    assign rd_tag_only_o = 1'b0;
    assign rd_prio_o     = HighPrio;
    assign miss_nc_o     = nc_q;
    assign miss_size_o   = size_q;
    assign miss_paddr_o  = {tag_q, idx_q, off_q};

    // A multi-hot hit vector means the tag array holds duplicate lines; it is
    // still treated as a hit, but flagged.
    hit_onehot_a : assert property (
        @(posedge clk_i) disable iff (rst_i)
        (state_q == TAG_CMP) |-> $onehot0(rd_hit_oh_i)
    );

endmodule

// File: tb/tb_wt_dcache_rd_client.sv
// -----------------------------------------------------------------------------
// tb_wt_dcache_rd_client
//
// Transaction-level bench: each load is described by a small record (address,
// hit vector, kill point, handshake delays). The driver walks the load through
// its protocol phases and, per cycle, states what the outputs must be from the
// load's own description. A separate process compares the DUT against those
// expectations in every cycle.
// -----------------------------------------------------------------------------
module tb_wt_dcache_rd_client;

    localparam int TW = 44;
    localparam int IW = 8;
    localparam int OW = 4;
    localparam int SA = 8;
    localparam int PW = TW + IW + OW;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          enable_i;
    logic          req_i;
    logic [IW-1:0] req_idx_i;
    logic [OW-1:0] req_off_i;
    logic [1:0]    req_size_i;
    logic          req_gnt_o;
    logic [TW-1:0] tag_i;
    logic          kill_i;
    logic          rsp_valid_o;
    logic [63:0]   rsp_data_o;
    logic          rd_req_o;
    logic          rd_ack_i;
    logic [IW-1:0] rd_idx_o;
    logic [OW-1:0] rd_off_o;
    logic [TW-1:0] rd_tag_o;
    logic          rd_tag_only_o;
    logic          rd_prio_o;
    logic [SA-1:0] rd_hit_oh_i;
    logic [63:0]   rd_data_i;
    logic          miss_req_o;
    logic          miss_ack_i;
    logic          miss_nc_o;
    logic [PW-1:0] miss_paddr_o;
    logic [1:0]    miss_size_o;
    logic          miss_rtrn_i;
    logic [63:0]   miss_data_i;

    wt_dcache_rd_client dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_i      (enable_i),
        .req_i         (req_i),
        .req_idx_i     (req_idx_i),
        .req_off_i     (req_off_i),
        .req_size_i    (req_size_i),
        .req_gnt_o     (req_gnt_o),
        .tag_i         (tag_i),
        .kill_i        (kill_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_data_o    (rsp_data_o),
        .rd_req_o      (rd_req_o),
        .rd_ack_i      (rd_ack_i),
        .rd_idx_o      (rd_idx_o),
        .rd_off_o      (rd_off_o),
        .rd_tag_o      (rd_tag_o),
        .rd_tag_only_o (rd_tag_only_o),
        .rd_prio_o     (rd_prio_o),
        .rd_hit_oh_i   (rd_hit_oh_i),
        .rd_data_i     (rd_data_i),
        .miss_req_o    (miss_req_o),
        .miss_ack_i    (miss_ack_i),
        .miss_nc_o     (miss_nc_o),
        .miss_paddr_o  (miss_paddr_o),
        .miss_size_o   (miss_size_o),
        .miss_rtrn_i   (miss_rtrn_i),
        .miss_data_i   (miss_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef enum int {K_NONE, K_CMP, K_REQ, K_REQACK, K_WAIT, K_RST} kill_e;

    typedef struct {
        logic [IW-1:0] idx;
        logic [OW-1:0] off;
        logic [1:0]    size;
        logic [TW-1:0] tag;
        logic          en;
        int            stall;     // cycles without rd_ack_i before the grant
        logic [SA-1:0] hit_oh;
        logic [63:0]   rdata;
        kill_e         kmode;
        int            kpos;      // cycle of kill/reset within its phase
        int            ack_dly;   // cycles of miss_req_o before miss_ack_i
        int            rtrn_dly;  // cycles after ack before miss_rtrn_i
        int            kw_dly;    // cycles a killed miss waits for its return
        logic [63:0]   mdata;
    } load_t;

    // Expectations for the current cycle, written by the driver.
    logic          chk_en = 1'b0;
    logic          exp_rd_req, exp_gnt, exp_rsp_valid, exp_miss_req, exp_nc;
    logic          chk_tag;
    logic [63:0]   exp_rsp_data;
    logic [IW-1:0] exp_idx;
    logic [OW-1:0] exp_off;
    logic [TW-1:0] exp_tag;
    logic [PW-1:0] exp_paddr;
    logic [1:0]    exp_size;

    int tests = 0;
    int fails = 0;

    // Observations used by the literal checks.
    int          cyc_cnt = 0;
    int          rsp_cnt = 0;
    int          gnt_cnt = 0;
    int          last_gnt_cyc = 0;
    int          last_rsp_cyc = 0;
    logic [63:0] last_rsp = '0;
    logic [PW-1:0] last_paddr = '0;
    logic        last_nc = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Per-cycle comparison, away from the rising edge.
    always begin
        @(negedge clk_i);
        #2;
        if (chk_en) begin
            check("rd_req", 64'(rd_req_o), 64'(exp_rd_req));
            check("req_gnt", 64'(req_gnt_o), 64'(exp_gnt));
            check("rsp_valid", 64'(rsp_valid_o), 64'(exp_rsp_valid));
            check("rsp_data", rsp_data_o, exp_rsp_data);
            check("miss_req", 64'(miss_req_o), 64'(exp_miss_req));
            check("rd_prio", 64'(rd_prio_o), 64'(1'b0));
            check("rd_tag_only", 64'(rd_tag_only_o), 64'(1'b0));
            if (exp_rd_req) begin
                check("rd_idx", 64'(rd_idx_o), 64'(exp_idx));
                check("rd_off", 64'(rd_off_o), 64'(exp_off));
            end
            if (chk_tag) begin
                check("rd_tag", 64'(rd_tag_o), 64'(exp_tag));
            end
            if (exp_miss_req) begin
                check("miss_paddr", 64'(miss_paddr_o), 64'(exp_paddr));
                check("miss_nc", 64'(miss_nc_o), 64'(exp_nc));
                check("miss_size", 64'(miss_size_o), 64'(exp_size));
            end
            if (req_gnt_o) begin
                gnt_cnt++;
                last_gnt_cyc = cyc_cnt;
            end
            if (rsp_valid_o) begin
                rsp_cnt++;
                last_rsp_cyc = cyc_cnt;
                last_rsp     = rsp_data_o;
            end
            if (miss_req_o) begin
                last_paddr = miss_paddr_o;
                last_nc    = miss_nc_o;
            end
        end
        cyc_cnt++;
    end

    function automatic logic [SA-1:0] rand_oh();
        int k;
        k = $urandom_range(0, SA + 3);
        return (k < SA) ? SA'(1 << k) : '0;
    endfunction

    // Advance to the next cycle: quiet inputs, nothing expected.
    task automatic next_cycle();
        @(negedge clk_i);
        rst_i       = 1'b0;
        enable_i    = 1'b0;
        req_i       = 1'b0;
        req_idx_i   = '0;
        req_off_i   = '0;
        req_size_i  = '0;
        tag_i       = '0;
        kill_i      = 1'b0;
        rd_ack_i    = 1'b0;
        rd_hit_oh_i = '0;
        rd_data_i   = '0;
        miss_ack_i  = 1'b0;
        miss_rtrn_i = 1'b0;
        miss_data_i = '0;
        exp_rd_req    = 1'b0;
        exp_gnt       = 1'b0;
        exp_rsp_valid = 1'b0;
        exp_rsp_data  = '0;
        exp_miss_req  = 1'b0;
        chk_tag       = 1'b0;
    endtask

    // Random values on inputs that the current phase must ignore.
    task automatic noise(input bit with_req);
        enable_i    = 1'($urandom_range(0, 1));
        req_size_i  = 2'($urandom);
        tag_i       = TW'({$urandom, $urandom});
        rd_hit_oh_i = rand_oh();
        rd_data_i   = {$urandom, $urandom};
        miss_rtrn_i = 1'($urandom_range(0, 1));
        miss_data_i = {$urandom, $urandom};
        if (with_req) begin
            req_i     = 1'($urandom_range(0, 1));
            rd_ack_i  = 1'($urandom_range(0, 1));
            req_idx_i = IW'($urandom);
            req_off_i = OW'($urandom);
        end
    endtask

    // A miss that was accepted and then killed: its return is swallowed.
    task automatic killed_drain(input load_t l);
        for (int e = 0; e <= l.kw_dly; e++) begin
            next_cycle();
            noise(1);
            miss_rtrn_i = (e == l.kw_dly);
        end
    endtask

    task automatic run_load(input load_t l);
        logic hit;
        // Arbitration: address presented until the grant.
        for (int s = 0; s <= l.stall; s++) begin
            next_cycle();
            noise(0);
            req_i      = 1'b1;
            req_idx_i  = l.idx;
            req_off_i  = l.off;
            req_size_i = l.size;
            enable_i   = l.en;
            rd_ack_i   = (s == l.stall);
            exp_rd_req = 1'b1;
            exp_idx    = l.idx;
            exp_off    = l.off;
            exp_gnt    = (s == l.stall);
        end
        // Tag compare, one cycle after the grant.
        next_cycle();
        noise(1);
        tag_i       = l.tag;
        rd_hit_oh_i = l.hit_oh;
        rd_data_i   = l.rdata;
        kill_i      = (l.kmode == K_CMP);
        chk_tag     = 1'b1;
        exp_tag     = l.tag;
        hit = (l.hit_oh != '0) && l.en;
        if (l.kmode == K_CMP) return;
        if (hit) begin
            exp_rsp_valid = 1'b1;
            exp_rsp_data  = l.rdata;
            return;
        end
        // Miss request held until acknowledged.
        for (int a = 0; a <= l.ack_dly; a++) begin
            next_cycle();
            noise(1);
            exp_miss_req = 1'b1;
            exp_paddr    = {l.tag, l.idx, l.off};
            exp_nc       = ~l.en;
            exp_size     = l.size;
            miss_ack_i   = (a == l.ack_dly);
            if (l.kmode == K_REQ && a == l.kpos) begin
                kill_i = 1'b1;
                return;
            end
            if (l.kmode == K_REQACK && a == l.ack_dly) kill_i = 1'b1;
        end
        if (l.kmode == K_REQACK) begin
            killed_drain(l);
            return;
        end
        // Waiting for the miss data.
        for (int r = 0; r <= l.rtrn_dly; r++) begin
            next_cycle();
            noise(1);
            miss_rtrn_i = (r == l.rtrn_dly);
            miss_data_i = l.mdata;
            if (l.kmode == K_WAIT && r == l.kpos) begin
                kill_i = 1'b1;
                if (r != l.rtrn_dly) killed_drain(l);
                return;
            end
            if (l.kmode == K_RST && r == l.kpos) begin
                rst_i       = 1'b1;
                req_i       = 1'b0;
                miss_rtrn_i = 1'b1;
                for (int p = 0; p < 2; p++) begin
                    next_cycle();
                    noise(1);
                    req_i       = 1'b0;
                    miss_rtrn_i = 1'b1;
                    miss_data_i = l.mdata;
                end
                return;
            end
            if (r == l.rtrn_dly) begin
                exp_rsp_valid = 1'b1;
                exp_rsp_data  = l.mdata;
            end
        end
    endtask

    function automatic load_t base_load(input logic [SA-1:0] hit_oh, input logic en);
        load_t l;
        l.idx = 8'h12; l.off = 4'h8; l.size = 2'd3; l.tag = TW'(44'hABC);
        l.en = en; l.stall = 0; l.hit_oh = hit_oh; l.rdata = 64'hDEAD;
        l.kmode = K_NONE; l.kpos = 0; l.ack_dly = 2; l.rtrn_dly = 2; l.kw_dly = 1;
        l.mdata = 64'hBEEF;
        return l;
    endfunction

    function automatic load_t rand_load();
        load_t l;
        int m;
        l.idx = IW'($urandom); l.off = OW'($urandom); l.size = 2'($urandom);
        l.tag = TW'({$urandom, $urandom}); l.en = ($urandom_range(0, 3) != 0);
        l.stall = $urandom_range(0, 3); l.hit_oh = rand_oh();
        l.rdata = {$urandom, $urandom}; l.mdata = {$urandom, $urandom};
        l.ack_dly = $urandom_range(0, 3); l.rtrn_dly = $urandom_range(0, 4);
        l.kw_dly = $urandom_range(0, 3); l.kpos = 0;
        m = $urandom_range(0, 19);
        if (m < 11)       l.kmode = K_NONE;
        else if (m < 13)  l.kmode = K_CMP;
        else if (m < 15)  l.kmode = K_REQ;
        else if (m < 17)  l.kmode = K_REQACK;
        else if (m < 19)  l.kmode = K_WAIT;
        else              l.kmode = K_RST;
        if (l.kmode == K_REQ) begin
            if (l.ack_dly == 0) l.ack_dly = 1;
            l.kpos = $urandom_range(0, l.ack_dly - 1);
        end
        if (l.kmode == K_WAIT || l.kmode == K_RST) l.kpos = $urandom_range(0, l.rtrn_dly);
        return l;
    endfunction

    // Wait until the compare process has seen the last driven cycle.
    task automatic settle();
        next_cycle();
        #3;
    endtask

    initial begin
        load_t l;
        int r0, g0;

        // Reset: every output low.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            rst_i  = 1'b1;
            chk_en = 1'b1;
        end

        // Hit: response one cycle after the grant.
        r0 = rsp_cnt;
        run_load(base_load(8'h04, 1'b1));
        settle();
        check("hit_data", last_rsp, 64'hDEAD);
        check("hit_count", 64'(rsp_cnt - r0), 64'd1);
        check("hit_latency", 64'(last_rsp_cyc - last_gnt_cyc), 64'd1);

        // Arbitration stall: three refused cycles, one grant.
        g0 = gnt_cnt;
        l = base_load(8'h04, 1'b1);
        l.stall = 3;
        l.rdata = 64'h5151;
        run_load(l);
        settle();
        check("stall_grants", 64'(gnt_cnt - g0), 64'd1);
        check("stall_data", last_rsp, 64'h5151);

        // Miss: paddr {0xABC,0x12,0x8}, cacheable, data from the return.
        l = base_load(8'h00, 1'b1);
        run_load(l);
        settle();
        check("miss_paddr_lit", 64'(last_paddr), 64'h0000_0000_00AB_C128);
        check("miss_nc_lit", 64'(last_nc), 64'd0);
        check("miss_data", last_rsp, 64'hBEEF);

        // Cache disabled: a hit vector is ignored, noncacheable miss instead.
        l = base_load(8'h01, 1'b0);
        l.mdata = 64'hCAFE;
        run_load(l);
        settle();
        check("nc_flag", 64'(last_nc), 64'd1);
        check("nc_data", last_rsp, 64'hCAFE);

        // Kill during tag compare: no response.
        r0 = rsp_cnt;
        l = base_load(8'h04, 1'b1);
        l.kmode = K_CMP;
        run_load(l);
        settle();
        check("kill_cmp_norsp", 64'(rsp_cnt - r0), 64'd0);

        // Kill while waiting: the return is dropped, the next load proceeds.
        l = base_load(8'h00, 1'b1);
        l.kmode = K_WAIT; l.kpos = 1; l.rtrn_dly = 3; l.kw_dly = 2;
        run_load(l);
        settle();
        check("kill_wait_norsp", 64'(rsp_cnt - r0), 64'd0);
        l = base_load(8'h80, 1'b1);
        l.rdata = 64'h7777;
        run_load(l);
        settle();
        check("after_kill_data", last_rsp, 64'h7777);

        // Reset while waiting: the late return produces nothing.
        r0 = rsp_cnt;
        l = base_load(8'h00, 1'b1);
        l.kmode = K_RST; l.kpos = 1; l.rtrn_dly = 3;
        run_load(l);
        settle();
        check("reset_norsp", 64'(rsp_cnt - r0), 64'd0);

        // Randomised loads, occasionally separated by quiet cycles.
        for (int n = 0; n < 300; n++) begin
            run_load(rand_load());
            if ($urandom_range(0, 3) == 0) next_cycle();
        end
        settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
